dcache_port_arbiter: RTL

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

---
 rtl/dcache_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: arbitrates load/store queue heads onto a single-outstanding d-cache port.
module dcache_port_arbiter #(
  parameter int LQ_IDX_W     = 3,
  parameter int SQ_IDX_W     = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_miss,
  input  logic                ld_req_valid,
  input  logic [31:0]         ld_req_addr,
  input  logic [LQ_IDX_W-1:0] ld_req_idx,
  output logic                ld_req_ready,
  input  logic                st_req_valid,
  input  logic [31:0]         st_req_addr,
  input  logic [31:0]         st_req_data,
  input  logic [SQ_IDX_W-1:0] st_req_idx,
  input  logic                sq_full,
  output logic                st_req_ready,
  output logic                dc_valid,
  output logic                dc_mem_action,
  output logic [31:0]         dc_addr,
  output logic [31:0]         dc_wdata,
  input  logic                dc_ready,
  input  logic                dc_miss,
  input  logic                dc_done,
  output logic                ld_done,
  output logic [LQ_IDX_W-1:0] ld_done_idx,
  output logic                st_done,
  output logic [SQ_IDX_W-1:0] st_done_idx,
  output logic                busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic is_ld_q, is_ld_d, squash_q, squash_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [LQ_IDX_W-1:0] lidx_q, lidx_d;
  logic [SQ_IDX_W-1:0] sidx_q, sidx_d;
  logic [CW-1:0] starve_q, starve_d;
  logic st_pri, gnt_ld, gnt_st, bm_ld, unused;
  always_comb begin
    unused = dc_miss;
    st_pri = st_req_valid && (sq_full || starve_q == CW'(STARVE_LIMIT));
    gnt_ld = state_q == IDLE && !rst && !st_pri && ld_req_valid && !branch_miss;
    gnt_st = state_q == IDLE && !rst && st_req_valid && !gnt_ld;
    bm_ld = branch_miss && is_ld_q;
    state_d = state_q;
    is_ld_d = is_ld_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    lidx_d = lidx_q;
    sidx_d = sidx_q;
    starve_d = starve_q;
    squash_d = squash_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    if (gnt_ld || gnt_st) begin
      state_d = ISSUE;
      is_ld_d = gnt_ld;
      addr_d = gnt_ld ? ld_req_addr : st_req_addr;
      wdata_d = gnt_st ? st_req_data : wdata_q;
      lidx_d = gnt_ld ? ld_req_idx : lidx_q;
      sidx_d = gnt_st ? st_req_idx : sidx_q;
      squash_d = 1'b0;
      starve_d = gnt_st ? '0 : (st_req_valid && starve_q != CW'(STARVE_LIMIT)) ? starve_q + CW'(1) : starve_q;
    end
    if (state_q == ISSUE) begin
      state_d = dc_ready ? WAIT : bm_ld ? IDLE : ISSUE;
      squash_d = dc_ready && bm_ld;
    end
    // a flush landing on the completion cycle still squashes the load
    if (state_q == WAIT) begin
      squash_d = squash_q || bm_ld;
      if (dc_done) begin
        state_d = IDLE;
        squash_d = 1'b0;
        ld_done_d = is_ld_q && !squash_q && !bm_ld;
        st_done_d = !is_ld_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_ld_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      lidx_q <= '0;
      sidx_q <= '0;
      starve_q <= '0;
      squash_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_ld_q <= is_ld_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      lidx_q <= lidx_d;
      sidx_q <= sidx_d;
      starve_q <= starve_d;
      squash_q <= squash_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
    end
  end
  assign ld_req_ready = gnt_ld;
  assign st_req_ready = gnt_st;
  assign dc_valid = state_q == ISSUE;
  assign dc_mem_action = is_ld_q;
  assign dc_addr = addr_q;
  assign dc_wdata = wdata_q;
  assign ld_done = ld_done_q;
  assign ld_done_idx = lidx_q;
  assign st_done = st_done_q;
  assign st_done_idx = sidx_q;
  assign busy = state_q != IDLE;
endmodule
